// File: rtl/bp_pkg.sv
// Shared types for the branch-predictor pattern-history table: 2-bit counter
// encoding and controller FSM states.
package bp_pkg;

   typedef logic [1:0] ctr_t;

   localparam ctr_t CTR_SNT = 2'b00;
   localparam ctr_t CTR_WNT = 2'b01;
   localparam ctr_t CTR_WT  = 2'b10;
   localparam ctr_t CTR_ST  = 2'b11;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } st_t;

endpackage

// File: rtl/bp_ctr_next.sv
// Two-bit saturating counter step: taken counts up to strong-T,
// not-taken counts down to strong-NT.
module bp_ctr_next
   import bp_pkg::*;
(
   input  ctr_t i_state,
   input  logic i_taken,
   output ctr_t o_next
);

   always_comb begin
      o_next = i_state;
      if (i_taken) begin
         if (i_state != CTR_ST) o_next = i_state + 2'd1;
      end else begin
         if (i_state != CTR_SNT) o_next = i_state - 2'd1;
      end
   end

endmodule

// File: rtl/bp_pht_ctrl.sv
// Pattern-history table controller: post-reset init sweep, one lookup and one
// read-modify-write update per cycle, saturating mispredict counter.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_INIT | sweep writes INIT_STATE to entry r_ptr each cycle, ports closed
//   ST_RUN  | lookups and updates accepted; left only through rst
module bp_pht_ctrl
   import bp_pkg::*;
#(
   parameter int   IDX_W      = 6,
   parameter ctr_t INIT_STATE = CTR_WNT,
   parameter int   MISS_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pred_valid,
   input  logic [IDX_W-1:0]  pred_idx,
   output logic              pred_ready,
   output logic              pred_rsp_valid,
   output logic              pred_taken,
   output logic [1:0]        pred_state,
   input  logic              upd_valid,
   input  logic [IDX_W-1:0]  upd_idx,
   input  logic              upd_taken,
   input  logic              upd_mispred,
   output logic              upd_ready,
   output logic              init_busy,
   output logic [MISS_W-1:0] miss_count
);

   localparam int DEPTH = 2**IDX_W;

   st_t               r_state;
   st_t               w_state_nxt;
   logic [IDX_W-1:0]  r_ptr;
   ctr_t              r_tab [DEPTH];
   logic              r_u1_vld;
   logic [IDX_W-1:0]  r_u1_idx;
   logic              r_u1_taken;
   logic              r_rsp_vld;
   ctr_t              r_rsp_state;
   logic [MISS_W-1:0] r_miss;

   logic              w_busy;
   logic              w_pred_acc;
   logic              w_upd_acc;
   logic              w_sweep_last;
   ctr_t              w_u1_cur;
   ctr_t              w_u1_nxt;
   ctr_t              w_lookup;

   assign w_busy       = rst | (r_state == ST_INIT);
   assign w_pred_acc   = pred_valid & ~w_busy;
   assign w_upd_acc    = upd_valid & ~w_busy;
   assign w_sweep_last = (r_ptr == IDX_W'(DEPTH-1));
   assign w_u1_cur     = r_tab[r_u1_idx];

   bp_ctr_next u_ctr_next (
      .i_state (w_u1_cur),
      .i_taken (r_u1_taken),
      .o_next  (w_u1_nxt)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_INIT;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (r_state == ST_INIT && w_sweep_last) w_state_nxt = ST_RUN;
   end

   always_ff @(posedge clk) begin
      if (rst)                    r_ptr <= '0;
      else if (r_state == ST_INIT) r_ptr <= r_ptr + IDX_W'(1);
   end

   // Single write port; a U1 write can never coincide with the sweep because
   // RUN is left only through rst, which also empties U1.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (r_state == ST_INIT) r_tab[r_ptr] <= INIT_STATE;
         else if (r_u1_vld)      r_tab[r_u1_idx] <= w_u1_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_u1_vld   <= 1'b0;
         r_u1_idx   <= '0;
         r_u1_taken <= 1'b0;
      end else begin
         r_u1_vld <= w_upd_acc;
         if (w_upd_acc) begin
            r_u1_idx   <= upd_idx;
            r_u1_taken <= upd_taken;
         end
      end
   end

   // Bypass the U1 result landing on the same edge the lookup is accepted.
   assign w_lookup = (r_u1_vld && r_u1_idx == pred_idx) ? w_u1_nxt : r_tab[pred_idx];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rsp_vld   <= 1'b0;
         r_rsp_state <= CTR_SNT;
      end else begin
         r_rsp_vld <= w_pred_acc;
         if (w_pred_acc) r_rsp_state <= w_lookup;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                                           r_miss <= '0;
      else if (w_upd_acc && upd_mispred && r_miss != '1) r_miss <= r_miss + MISS_W'(1);
   end

   assign init_busy      = w_busy;
   assign pred_ready     = ~w_busy;
   assign upd_ready      = ~w_busy;
   assign pred_rsp_valid = r_rsp_vld;
   assign pred_state     = r_rsp_state;
   assign pred_taken     = r_rsp_state[1];
   assign miss_count     = r_miss;

endmodule

// File: tb/tb_bp_pht_ctrl.sv
// Bench for bp_pht_ctrl: directed scenarios plus random traffic, all checked
// against a per-edge behavioural table model.
module tb_bp_pht_ctrl;

   localparam int IDX_W    = 6;
   localparam int MISS_W   = 4;
   localparam int DEPTH    = 64;
   localparam int MISS_MAX = 15;
   localparam int INIT_V   = 1;

   logic              clk;
   logic              rst;
   logic              pred_valid;
   logic [IDX_W-1:0]  pred_idx;
   logic              pred_ready;
   logic              pred_rsp_valid;
   logic              pred_taken;
   logic [1:0]        pred_state;
   logic              upd_valid;
   logic [IDX_W-1:0]  upd_idx;
   logic              upd_taken;
   logic              upd_mispred;
   logic              upd_ready;
   logic              init_busy;
   logic [MISS_W-1:0] miss_count;

   bp_pht_ctrl #(.IDX_W(IDX_W), .INIT_STATE(2'b01), .MISS_W(MISS_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .pred_valid     (pred_valid),
      .pred_idx       (pred_idx),
      .pred_ready     (pred_ready),
      .pred_rsp_valid (pred_rsp_valid),
      .pred_taken     (pred_taken),
      .pred_state     (pred_state),
      .upd_valid      (upd_valid),
      .upd_idx        (upd_idx),
      .upd_taken      (upd_taken),
      .upd_mispred    (upd_mispred),
      .upd_ready      (upd_ready),
      .init_busy      (init_busy),
      .miss_count     (miss_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: table contents as integers, busy cycles left, last response.
   int m_tab [DEPTH];
   int m_busy      = 0;
   int m_miss      = 0;
   int m_rsp_vld   = 0;
   int m_rsp_state = 0;
   bit busy_seen;

   task automatic chk(input string tag, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
      end
   endtask

   // One clock: drive inputs, check readiness, advance model and DUT by one edge.
   task automatic cyc(input bit r, input bit pv, input int pidx,
                      input bit uv, input int uidx, input bit ut, input bit um);
      int s;
      rst         = r;
      pred_valid  = pv;
      pred_idx    = IDX_W'(pidx);
      upd_valid   = uv;
      upd_idx     = IDX_W'(uidx);
      upd_taken   = ut;
      upd_mispred = um;
      #1;
      chk("pred_ready", int'(pred_ready), int'(!(r || m_busy > 0)));
      chk("upd_ready",  int'(upd_ready),  int'(!(r || m_busy > 0)));
      busy_seen = init_busy;
      if (r) begin
         m_busy      = DEPTH;
         m_rsp_vld   = 0;
         m_rsp_state = 0;
         m_miss      = 0;
         for (int i = 0; i < DEPTH; i++) m_tab[i] = INIT_V;
      end else if (m_busy > 0) begin
         m_busy--;
         m_rsp_vld = 0;
      end else begin
         m_rsp_vld = pv;
         if (pv) m_rsp_state = m_tab[pidx];
         if (uv) begin
            s = m_tab[uidx];
            s = ut ? ((s < 3) ? s + 1 : 3) : ((s > 0) ? s - 1 : 0);
            m_tab[uidx] = s;
            if (um && m_miss < MISS_MAX) m_miss++;
         end
      end
      @(posedge clk);
      #1;
      chk("rsp_valid", int'(pred_rsp_valid), m_rsp_vld);
      if (m_rsp_vld != 0) begin
         chk("rsp_state", int'(pred_state), m_rsp_state);
         chk("rsp_taken", int'(pred_taken), m_rsp_state / 2);
      end
      chk("miss_count", int'(miss_count), m_miss);
      chk("init_busy",  int'(init_busy), int'(r || m_busy > 0));
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic upd(input int idx, input bit t, input bit m);
      cyc(0, 0, 0, 1, idx, t, m);
   endtask

   task automatic do_pred(input string tag, input int idx, input int exp);
      cyc(0, 1, idx, 0, 0, 0, 0);
      chk(tag, int'(pred_state), exp);
      chk(tag, int'(pred_taken), exp / 2);
   endtask

   task automatic count_busy(input string tag);
      int n;
      n = 0;
      for (int i = 0; i < 200; i++) begin
         idle();
         if (busy_seen) n++;
         else break;
      end
      chk(tag, n, DEPTH);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; pred_valid = 1'b0; pred_idx = '0;
      upd_valid = 1'b0; upd_idx = '0; upd_taken = 1'b0; upd_mispred = 1'b0;

      // Reset state and init sweep length
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("rst_rsp_valid", int'(pred_rsp_valid), 0);
      chk("rst_state",     int'(pred_state), 0);
      chk("rst_taken",     int'(pred_taken), 0);
      chk("rst_miss",      int'(miss_count), 0);
      chk("rst_busy",      int'(init_busy), 1);
      count_busy("t1_busy_len");
      do_pred("t1_idx0",  0,  1);
      do_pred("t1_idx37", 37, 1);
      do_pred("t1_idx63", 63, 1);

      // Saturation up and down
      upd(5, 1, 0);
      upd(5, 1, 0);
      idle();
      do_pred("t2_up", 5, 3);
      for (int i = 0; i < 4; i++) upd(5, 0, 0);
      idle();
      do_pred("t2_down", 5, 0);
      upd(5, 0, 0);
      idle();
      do_pred("t2_floor", 5, 0);

      // Bypass from U1, then same-cycle lookup and update
      upd(9, 1, 0);
      do_pred("t3_bypass", 9, 2);
      upd(9, 0, 0);
      idle();
      cyc(0, 1, 9, 1, 9, 1, 0);
      chk("t3_same", int'(pred_state), 1);
      idle();
      do_pred("t3_after", 9, 2);

      // Reset mid-sweep and with an update in flight
      cyc(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 30; i++) idle();
      cyc(1, 0, 0, 0, 0, 0, 0);
      count_busy("t4_busy_mid");
      upd(12, 1, 1);
      cyc(1, 0, 0, 0, 0, 0, 0);
      count_busy("t4_busy_upd");
      chk("t4_miss", int'(miss_count), 0);
      for (int i = 0; i < DEPTH; i++) do_pred("t4_entry", i, 1);

      // Mispredict counter saturation
      for (int i = 0; i < 5; i++) upd($urandom_range(0, 63), 1'($urandom_range(0, 1)), 1);
      chk("t5_miss5", int'(miss_count), 5);
      for (int i = 0; i < 3; i++) upd($urandom_range(0, 63), 1'($urandom_range(0, 1)), 0);
      chk("t5_miss_hold", int'(miss_count), 5);
      for (int i = 0; i < 20; i++) upd($urandom_range(0, 63), 1'($urandom_range(0, 1)), 1);
      chk("t5_miss_sat", int'(miss_count), 15);
      upd(3, 1, 0);
      chk("t5_miss_sat_hold", int'(miss_count), 15);

      // Random traffic, narrow index range to force collisions
      for (int i = 0; i < 10000; i++) begin
         bit r, pv, uv, ut, um;
         int pidx, uidx;
         r    = ($urandom_range(0, 2999) == 0);
         pv   = 1'($urandom_range(0, 1));
         uv   = 1'($urandom_range(0, 1));
         ut   = 1'($urandom_range(0, 1));
         um   = ($urandom_range(0, 7) == 0);
         pidx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 7);
         uidx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 7);
         cyc(r, pv, pidx, uv, uidx, ut, um);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
